// File: rtl/switch_route_allocator.sv
// Route allocator: grants each output port to one input at a time, round-robin per output,
// and holds every reservation until the owning input relieves it.
module switch_route_allocator #(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               routeReserveRequestValid,
  input  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic [N-1:0]               routeRelieve,
  output logic [N-1:0]               routeReserveStatus,
  output logic [N*REQUEST_WIDTH-1:0] outSelect,
  output logic [N-1:0]               outBusy
);

  localparam int W = REQUEST_WIDTH;

  logic [W-1:0] w_req_idx  [N];
  logic [N-1:0] w_elig;
  logic [N-1:0] w_held;
  logic [W-1:0] w_held_idx [N];
  logic [N-1:0] w_grant;
  logic [W-1:0] w_winner   [N];

  // Per-input state: held flag and the output index it owns.
  for (genvar gi = 0; gi < N; gi++) begin : g_in
    logic         r_held;
    logic [W-1:0] r_held_idx;
    logic         w_won;

    assign w_req_idx[gi]  = routeReserveRequest[gi*W +: W];
    assign w_elig[gi]     = routeReserveRequestValid[gi] && !r_held &&
                            (int'(w_req_idx[gi]) < N);
    assign w_held[gi]     = r_held;
    assign w_held_idx[gi] = r_held_idx;

    always_comb begin
      w_won = 1'b0;
      for (int o = 0; o < N; o++) begin
        if (w_grant[o] && (w_winner[o] == W'(gi))) begin
          w_won = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_held     <= 1'b0;
        r_held_idx <= '0;
      end else if (routeRelieve[gi] && r_held) begin
        r_held     <= 1'b0;
      end else if (w_won) begin
        r_held     <= 1'b1;
        r_held_idx <= w_req_idx[gi];
      end
    end

    assign routeReserveStatus[gi] = r_held;
  end

  // Per-output state: busy flag, owner and round-robin pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_out
    logic         r_busy;
    logic [W-1:0] r_owner;
    logic [W-1:0] r_ptr;
    logic [N-1:0] w_hit;
    logic         w_found;
    logic [W-1:0] w_win;
    logic [W-1:0] w_cand;
    logic         w_rel;

    always_comb begin
      w_hit = '0;
      for (int i = 0; i < N; i++) begin
        w_hit[i] = w_elig[i] && (w_req_idx[i] == W'(gi));
      end
    end

    // A busy output is never granted, so a same-cycle relieve frees it only after the edge.
    always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int k = 0; k < N; k++) begin
        w_cand = W'((int'(r_ptr) + k) % N);
        if (!w_found && !r_busy && w_hit[w_cand]) begin
          w_found = 1'b1;
          w_win   = w_cand;
        end
      end
    end

    always_comb begin
      w_rel = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (w_held[i] && routeRelieve[i] && (w_held_idx[i] == W'(gi))) begin
          w_rel = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_busy  <= 1'b0;
        r_owner <= '0;
        r_ptr   <= '0;
      end else if (w_found) begin
        r_busy  <= 1'b1;
        r_owner <= w_win;
        r_ptr   <= (w_win == W'(N-1)) ? '0 : w_win + W'(1);
      end else if (w_rel) begin
        r_busy  <= 1'b0;
      end
    end

    assign w_grant[gi]             = w_found;
    assign w_winner[gi]            = w_win;
    assign outBusy[gi]             = r_busy;
    assign outSelect[gi*W +: W]    = r_owner;
  end

endmodule

// File: tb/tb_switch_route_allocator.sv
// Bench for switch_route_allocator: directed and random stimulus, reference model feeding a
// scoreboard queue that a separate monitor drains after every clock edge.
module tb_switch_route_allocator;
  localparam int N = 4;
  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   v, rel, st, bz;
  logic [N*W-1:0] ix, sl;

  logic [2:0] v3, rel3, st3, bz3;
  logic [5:0] ix3, sl3;

  switch_route_allocator #(.N(N), .REQUEST_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .routeReserveRequestValid(v), .routeReserveRequest(ix), .routeRelieve(rel),
    .routeReserveStatus(st), .outSelect(sl), .outBusy(bz)
  );

  switch_route_allocator #(.N(3), .REQUEST_WIDTH(2)) dut3 (
    .clk(clk), .rst(rst),
    .routeReserveRequestValid(v3), .routeReserveRequest(ix3), .routeRelieve(rel3),
    .routeReserveStatus(st3), .outSelect(sl3), .outBusy(bz3)
  );

  typedef struct packed {
    logic [N-1:0]   st;
    logic [N-1:0]   bz;
    logic [N*W-1:0] sl;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: owner per output (-1 free), last owner, output held per input (-1 none), pointer.
  int m_owner[N];
  int m_last[N];
  int m_held[N];
  int m_ptr[N];

  task automatic m_reset();
    for (int k = 0; k < N; k++) begin
      m_owner[k] = -1; m_last[k] = 0; m_held[k] = -1; m_ptr[k] = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  // Applies one cycle of inputs at a negedge and queues the state expected after the next edge.
  task automatic step(input logic [N-1:0] sv, input logic [N*W-1:0] six, input logic [N-1:0] srel);
    int   win[N];
    int   best, d, q;
    exp_t e;
    v = sv; ix = six; rel = srel;
    for (int o = 0; o < N; o++) begin
      win[o] = -1;
      if (m_owner[o] < 0) begin
        best = N;
        for (int i = 0; i < N; i++) begin
          q = int'(six[i*W +: W]);
          if (sv[i] && m_held[i] < 0 && q < N && q == o) begin
            d = (i - m_ptr[o] + N) % N;
            if (d < best) begin best = d; win[o] = i; end
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (srel[i] && m_held[i] >= 0) begin
        m_owner[m_held[i]] = -1;
        m_held[i] = -1;
      end
    end
    for (int o = 0; o < N; o++) begin
      if (win[o] >= 0) begin
        m_owner[o] = win[o]; m_last[o] = win[o];
        m_held[win[o]] = o;  m_ptr[o] = (win[o] + 1) % N;
      end
    end
    for (int k = 0; k < N; k++) begin
      e.st[k]       = (m_held[k] >= 0);
      e.bz[k]       = (m_owner[k] >= 0);
      e.sl[k*W +: W] = W'(m_last[k]);
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("status", 32'(st), 32'(e.st));
        chk("busy",   32'(bz), 32'(e.bz));
        chk("select", 32'(sl), 32'(e.sl));
      end
    end
  end

  initial begin : main
    rst = 1'b1; v = '0; ix = '0; rel = '0;
    v3 = '0; ix3 = '0; rel3 = '0;
    m_reset();
    #1 rst = 1'b0;
    #1;
    chk("reset_status", 32'(st), 32'h0);
    chk("reset_busy",   32'(bz), 32'h0);
    chk("reset_select", 32'(sl), 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // single reservation and relieve
    step(4'b0001, pk(3,0,0,0), 4'b0000);
    step(4'b0000, pk(0,0,0,0), 4'b0000);
    step(4'b0000, pk(0,0,0,0), 4'b0001);
    step(4'b0000, pk(0,0,0,0), 4'b0000);
    // contention on out1, round-robin through in0, in1, in2, then ptr=3 favours in3
    step(4'b0111, pk(1,1,1,0), 4'b0000);
    step(4'b0110, pk(1,1,1,0), 4'b0001);
    step(4'b0110, pk(1,1,1,0), 4'b0000);
    step(4'b0100, pk(1,1,1,0), 4'b0010);
    step(4'b0100, pk(1,1,1,0), 4'b0000);
    step(4'b0000, pk(1,1,1,0), 4'b0100);
    step(4'b1001, pk(1,0,0,1), 4'b0000);
    step(4'b0001, pk(1,0,0,1), 4'b1000);
    step(4'b0001, pk(1,0,0,1), 4'b0000);
    step(4'b0000, pk(0,0,0,0), 4'b0001);
    // four parallel grants, then release all
    step(4'b1111, pk(1,0,3,2), 4'b0000);
    step(4'b0000, pk(0,0,0,0), 4'b1111);
    // relieve by owner colliding with a request from another input
    step(4'b0001, pk(2,0,0,0), 4'b0000);
    step(4'b0010, pk(2,2,0,0), 4'b0001);
    step(4'b0010, pk(2,2,0,0), 4'b0000);
    step(4'b0000, pk(0,0,0,0), 4'b0010);
    // self relieve+request, held input requesting again, relieve while idle
    step(4'b0001, pk(2,0,0,0), 4'b0000);
    step(4'b0001, pk(2,0,0,0), 4'b0001);
    step(4'b0001, pk(2,0,0,0), 4'b0000);
    step(4'b0001, pk(3,0,0,0), 4'b0000);
    step(4'b0000, pk(0,0,0,0), 4'b0100);
    step(4'b0000, pk(0,0,0,0), 4'b0001);

    for (int n = 0; n < 400; n++) begin
      step(4'($urandom), 8'($urandom), 4'($urandom & $urandom));
    end

    // async reset with three reservations active
    step(4'b0000, pk(0,0,0,0), 4'b1111);
    step(4'b0111, pk(0,1,2,0), 4'b0000);
    v = '0; rel = '0;
    #2 rst = 1'b0;
    #1;
    chk("async_status", 32'(st), 32'h0);
    chk("async_busy",   32'(bz), 32'h0);
    chk("async_select", 32'(sl), 32'h0);
    @(negedge clk);
    m_reset();
    rst = 1'b1;
    step(4'b1111, pk(0,0,0,0), 4'b0000);
    step(4'b1110, pk(0,0,0,0), 4'b0001);
    step(4'b1110, pk(0,0,0,0), 4'b0000);
    step(4'b0000, pk(0,0,0,0), 4'b0010);

    // N=3 instance: index 3 is out of range and must never be granted
    v3 = 3'b011; ix3 = {2'd0, 2'd2, 2'd3};
    repeat (3) @(negedge clk);
    chk("n3_status", 32'(st3), 32'h2);
    chk("n3_busy",   32'(bz3), 32'h4);
    chk("n3_select", 32'(sl3[5:4]), 32'h1);
    v3 = 3'b001;
    repeat (3) @(negedge clk);
    chk("n3_status_hold", 32'(st3), 32'h2);
    chk("n3_busy_hold",   32'(bz3), 32'h4);

    @(negedge clk); @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
